imem_boot_loader: RTL and testbench

- Upstream feeder for cpu_single_cycle.
- Receives a byte stream (valid/ready) carrying a program image and assembles little-endian 32-bit words.
- Writes each word into the instruction memory write port at consecutive word addresses from 0.
- Holds the CPU in reset (cpu_rst_n low) until the image is fully loaded, then releases it.

---
 rtl/imem_boot_loader_if.sv | 22 ++
 rtl/imem_boot_loader.sv | 173 +++++++++++++++++
 tb/tb_imem_boot_loader.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_boot_loader_if.sv
// Byte-stream input and imem write port of the boot loader.
// The loader uses the slave modport; the stream source uses master.
interface imem_boot_loader_if #(
    parameter int unsigned ADDR_WIDTH = 8
);
    logic [7:0]            in_data;
    logic                  in_valid;
    logic                  in_ready;
    logic                  imem_we;
    logic [ADDR_WIDTH-1:0] imem_addr;
    logic [31:0]           imem_wdata;

    modport master (
        output in_data, in_valid,
        input  in_ready, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        input  in_data, in_valid,
        output in_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/imem_boot_loader.sv
// Loads a length-prefixed little-endian program image into imem, then releases the CPU reset.
// Optional trailing XOR checksum byte and csum_err output when BOOT_CHECKSUM_EN is defined.
module imem_boot_loader #(
    parameter int unsigned ADDR_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    imem_boot_loader_if.slave        bus,
    input  logic                     restart,
    output logic                     cpu_rst_n,
    output logic                     done,
    output logic                     overflow,
    output logic [15:0]              words_loaded
`ifdef BOOT_CHECKSUM_EN
    ,
    output logic                     csum_err
`endif
);

    localparam int unsigned Depth = 2 ** ADDR_WIDTH;

`ifdef BOOT_CHECKSUM_EN
    typedef enum logic [2:0] {StLen0, StLen1, StData, StCheck, StDone} state_t;
    localparam state_t StEnd = StCheck;
`else
    typedef enum logic [2:0] {StLen0, StLen1, StData, StDone} state_t;
    localparam state_t StEnd = StDone;
`endif

    state_t                state_q, state_d;
    logic [15:0]           n_q, n_d;
    logic [1:0]            idx_q, idx_d;
    logic [23:0]           lane_q, lane_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic                  ready_q, ready_d;
    logic                  done_q, done_d;
    logic                  cpu_rst_n_q, cpu_rst_n_d;
    logic                  ovf_q, ovf_d;
    logic [15:0]           wl_q, wl_d;
    logic [7:0]            xor_q, xor_d;
    logic                  cerr_q, cerr_d;
    logic                  fire;

    assign fire = bus.in_valid && ready_q;

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        idx_d   = idx_q;
        lane_d  = lane_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        ovf_d   = ovf_q;
        wl_d    = wl_q;
        xor_d   = xor_q;
        cerr_d  = cerr_q;

        unique case (state_q)
            StLen0: begin
                if (fire) begin
                    n_d[7:0] = bus.in_data;
                    state_d  = StLen1;
                end
            end
            StLen1: begin
                if (fire) begin
                    n_d[15:8] = bus.in_data;
                    idx_d     = 2'd0;
                    state_d   = ({bus.in_data, n_q[7:0]} == 16'd0) ? StEnd : StData;
                end
            end
            StData: begin
                if (fire) begin
                    xor_d = xor_q ^ bus.in_data;
                    idx_d = idx_q + 2'd1;
                    // Bytes arrive LSB first, so shift each new byte in from the top.
                    lane_d = {bus.in_data, lane_q[23:8]};
                    if (idx_q == 2'd3) begin
                        wl_d = wl_q + 16'd1;
                        if (32'(wl_q) < Depth) begin
                            we_d    = 1'b1;
                            addr_d  = ADDR_WIDTH'(wl_q);
                            wdata_d = {bus.in_data, lane_q};
                        end else begin
                            ovf_d = 1'b1;
                        end
                        if (wl_q + 16'd1 == n_q) begin
                            state_d = StEnd;
                        end
                    end
                end
            end
`ifdef BOOT_CHECKSUM_EN
            StCheck: begin
                if (fire) begin
                    cerr_d  = (bus.in_data != xor_q);
                    state_d = StDone;
                end
            end
`endif
            StDone: begin
                if (restart) begin
                    state_d = StLen0;
                    ovf_d   = 1'b0;
                    wl_d    = 16'd0;
                    xor_d   = 8'd0;
                    cerr_d  = 1'b0;
                    idx_d   = 2'd0;
                end
            end
            default: state_d = StLen0;
        endcase

        ready_d = (state_d != StDone);
        // done/cpu_rst_n follow state one cycle late so they never overlap the last write.
        done_d  = (state_q == StDone) && !restart;
`ifdef BOOT_CHECKSUM_EN
        cpu_rst_n_d = done_d && !cerr_q;
`else
        cpu_rst_n_d = done_d;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StLen0;
            n_q         <= '0;
            idx_q       <= '0;
            lane_q      <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            ready_q     <= 1'b0;
            done_q      <= 1'b0;
            cpu_rst_n_q <= 1'b0;
            ovf_q       <= 1'b0;
            wl_q        <= '0;
            xor_q       <= '0;
            cerr_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            n_q         <= n_d;
            idx_q       <= idx_d;
            lane_q      <= lane_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            ready_q     <= ready_d;
            done_q      <= done_d;
            cpu_rst_n_q <= cpu_rst_n_d;
            ovf_q       <= ovf_d;
            wl_q        <= wl_d;
            xor_q       <= xor_d;
            cerr_q      <= cerr_d;
        end
    end

    assign bus.in_ready   = ready_q;
    assign bus.imem_we    = we_q;
    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = wdata_q;
    assign cpu_rst_n      = cpu_rst_n_q;
    assign done           = done_q;
    assign overflow       = ovf_q;
    assign words_loaded   = wl_q;
`ifdef BOOT_CHECKSUM_EN
    assign csum_err       = cerr_q;
`endif

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader: expected imem writes are queued as frames are sent
// and checked by a monitor when imem_we fires.
`timescale 1ns/1ps
module tb_imem_boot_loader;

    localparam int unsigned AW = 2;

    typedef struct {
        logic [AW-1:0] addr;
        logic [31:0]   data;
        int            cyc;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        restart = 1'b0;
    logic        cpu_rst_n;
    logic        done;
    logic        overflow;
    logic [15:0] words_loaded;
`ifdef BOOT_CHECKSUM_EN
    logic        csum_err;
`endif

    int     n_checks = 0;
    int     n_pass = 0;
    int     cyc = 0;
    logic [7:0] run_xor = 8'd0;
    wr_t    exp_q[$];

    imem_boot_loader_if #(.ADDR_WIDTH(AW)) bus ();

    imem_boot_loader #(.ADDR_WIDTH(AW)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .restart      (restart),
        .cpu_rst_n    (cpu_rst_n),
        .done         (done),
        .overflow     (overflow),
        .words_loaded (words_loaded)
`ifdef BOOT_CHECKSUM_EN
        ,
        .csum_err     (csum_err)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Scoreboard monitor: every write must match the oldest queued expectation.
    always @(negedge clk) begin
        if (bus.imem_we === 1'b1) begin
            chk("we_while_cpu_running", {31'd0, cpu_rst_n}, 32'd0);
            chk("write_expected", {31'd0, exp_q.size() > 0}, 32'd1);
            if (exp_q.size() > 0) begin
                wr_t e;
                e = exp_q.pop_front();
                chk("imem_addr", {30'd0, bus.imem_addr}, {30'd0, e.addr});
                chk("imem_wdata", bus.imem_wdata, e.data);
                chk("write_cycle", cyc, e.cyc);
            end
        end
    end

    // Present a byte from the negedge; returns the cycle number of its handshake.
    task automatic send_byte(input logic [7:0] b, output int hs);
        int n;
        n = 0;
        @(negedge clk);
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        while (bus.in_ready !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("in_ready_wait", {31'd0, bus.in_ready}, 32'd1);
        hs = cyc;
        @(posedge clk);
    endtask

    task automatic idle();
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic send_hdr(input logic [15:0] n);
        int hs;
        run_xor = 8'd0;
        send_byte(n[7:0], hs);
        send_byte(n[15:8], hs);
    endtask

    // Sends one word LSB first; queues the write if it should land in imem.
    task automatic send_word(input logic [31:0] w, input logic [AW-1:0] a, input bit wr,
                             input bit bubbles, output int hs);
        for (int i = 0; i < 4; i++) begin
            send_byte(w[8*i +: 8], hs);
            run_xor = run_xor ^ w[8*i +: 8];
            if (bubbles) idle();
        end
        if (wr) exp_q.push_back('{addr: a, data: w, cyc: hs + 1});
    endtask

    task automatic send_csum(input logic [7:0] x);
`ifdef BOOT_CHECKSUM_EN
        int hs;
        send_byte(x, hs);
`else
        if (x != x) $error("FAIL unreachable");
`endif
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (done !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk(tag, {31'd0, done}, 32'd1);
    endtask

    task automatic do_restart();
        @(negedge clk);
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        chk("restart_done", {31'd0, done}, 32'd0);
        chk("restart_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd0);
        chk("restart_words", {16'd0, words_loaded}, 32'd0);
        chk("restart_overflow", {31'd0, overflow}, 32'd0);
        chk("restart_ready", {31'd0, bus.in_ready}, 32'd1);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_in_ready"}, {31'd0, bus.in_ready}, 32'd0);
        chk({tag, "_we"}, {31'd0, bus.imem_we}, 32'd0);
        chk({tag, "_addr"}, {30'd0, bus.imem_addr}, 32'd0);
        chk({tag, "_wdata"}, bus.imem_wdata, 32'd0);
        chk({tag, "_cpu_rst_n"}, {31'd0, cpu_rst_n}, 32'd0);
        chk({tag, "_done"}, {31'd0, done}, 32'd0);
        chk({tag, "_overflow"}, {31'd0, overflow}, 32'd0);
        chk({tag, "_words"}, {16'd0, words_loaded}, 32'd0);
    endtask

    initial begin
        int hs, first;
        bus.in_data  = 8'd0;
        bus.in_valid = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk_reset_vals("reset");
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", {31'd0, bus.in_ready}, 32'd1);

        // Single word
        send_hdr(16'd1);
        send_word(32'h02A00093, 2'd0, 1'b1, 1'b0, hs);
        send_csum(run_xor);
        idle();
        wait_done("single_done");
        chk("single_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd1);
        chk("single_words", {16'd0, words_loaded}, 32'd1);
        chk("single_ready_low", {31'd0, bus.in_ready}, 32'd0);
        chk("single_all_written", exp_q.size(), 32'd0);
        do_restart();

        // Three words back-to-back
        send_hdr(16'd3);
        send_word(32'h11111111, 2'd0, 1'b1, 1'b0, first);
        first = first - 3;
        exp_q[0].cyc = first + 4;
        send_word(32'h22222222, 2'd1, 1'b1, 1'b0, hs);
        exp_q[$].cyc = first + 8;
        send_word(32'h33333333, 2'd2, 1'b1, 1'b0, hs);
        exp_q[$].cyc = first + 12;
        send_csum(run_xor);
        idle();
        wait_done("three_done");
        chk("three_words", {16'd0, words_loaded}, 32'd3);
        chk("three_all_written", exp_q.size(), 32'd0);
        do_restart();

        // Bubbles between every byte
        send_hdr(16'd1);
        send_word(32'h02A00093, 2'd0, 1'b1, 1'b1, hs);
        send_csum(run_xor);
        idle();
        wait_done("bubble_done");
        chk("bubble_words", {16'd0, words_loaded}, 32'd1);
        chk("bubble_all_written", exp_q.size(), 32'd0);
        do_restart();

        // Zero-length frame: done two cycles after the last handshake
        send_hdr(16'd0);
        send_csum(8'd0);
        idle();
        chk("zero_done_entry", {31'd0, done}, 32'd0);
        @(negedge clk);
        chk("zero_done", {31'd0, done}, 32'd1);
        chk("zero_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd1);
        chk("zero_words", {16'd0, words_loaded}, 32'd0);
        do_restart();

        // Overflow: depth 4, five words
        send_hdr(16'd5);
        for (int k = 0; k < 5; k++) begin
            send_word(32'hA5000000 + 32'(k), AW'(k), k < 4, 1'b0, hs);
        end
        send_csum(run_xor);
        idle();
        wait_done("ovf_done");
        chk("ovf_flag", {31'd0, overflow}, 32'd1);
        chk("ovf_words", {16'd0, words_loaded}, 32'd5);
        chk("ovf_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd1);
        chk("ovf_all_written", exp_q.size(), 32'd0);
        do_restart();

        // Reset in the middle of the second word
        send_hdr(16'd2);
        send_word(32'hCAFEF00D, 2'd0, 1'b1, 1'b0, hs);
        send_byte(8'h12, hs);
        send_byte(8'h34, hs);
        idle();
        @(negedge clk);
        chk("midload_words", {16'd0, words_loaded}, 32'd1);
        rst = 1'b1;
        #1;
        chk_reset_vals("midreset");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        send_hdr(16'd1);
        send_word(32'hDEADBEEF, 2'd0, 1'b1, 1'b0, hs);
`ifdef BOOT_CHECKSUM_EN
        send_csum(~run_xor);
        idle();
        wait_done("bad_csum_done");
        chk("bad_csum_err", {31'd0, csum_err}, 32'd1);
        chk("bad_csum_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd0);
`else
        idle();
        wait_done("after_reset_done");
        chk("after_reset_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd1);
`endif
        chk("after_reset_words", {16'd0, words_loaded}, 32'd1);
        chk("after_reset_all_written", exp_q.size(), 32'd0);

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
